// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: FIFO-side and SPI-pin signals of the SPI shift engine.
interface spi_shift_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
);
  logic                  enable;
  logic                  cpol;
  logic                  cpha;
  logic [4:0]            datalen;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic                  tfifo_empty;
  logic [DATA_WIDTH-1:0] tfifo_rdata;
  logic                  tfifo_ren;
  logic                  rfifo_full;
  logic [DATA_WIDTH-1:0] rfifo_wdata;
  logic                  rfifo_wen;
  logic                  ovr_clr;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  ss_n;
  logic                  busy;
  logic                  rx_overrun;
  modport master (
    input  enable, cpol, cpha, datalen, clk_div, tfifo_empty, tfifo_rdata, rfifo_full, ovr_clr, miso,
    output tfifo_ren, rfifo_wdata, rfifo_wen, sclk, mosi, ss_n, busy, rx_overrun
  );
  modport slave (
    output enable, cpol, cpha, datalen, clk_div, tfifo_empty, tfifo_rdata, rfifo_full, ovr_clr, miso,
    input  tfifo_ren, rfifo_wdata, rfifo_wen, sclk, mosi, ss_n, busy, rx_overrun
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master serialiser between the TX/RX FIFOs and the SPI pins, bit 0 first.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  spi_shift_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, LEAD, SHIFT, TRAIL} state_t;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q;
  logic [DIV_WIDTH-1:0]  cnt_q, div_q;
  logic [5:0]            edge_q;
  logic [4:0]            len_q;
  logic                  cpol_q, cpha_q, first_q, sclk_q, mosi_q, ss_n_q, ovr_q;
  logic                  tick, go, last, smp, trail_done, push_slot;
  assign tick       = cnt_q == '0;
  assign go         = bus.enable & !bus.tfifo_empty;
  assign last       = edge_q == {len_q, 1'b1};
  assign smp        = edge_q[0] == cpha_q;
  assign trail_done = (state_q == TRAIL) & !first_q & tick;
  assign push_slot  = (state_q == TRAIL) & first_q;
  // Pop and push are decoded from live FIFO flags so they can never fire on empty/full.
  assign bus.tfifo_ren   = go & ((state_q == IDLE) | trail_done);
  assign bus.rfifo_wen   = push_slot & !bus.rfifo_full;
  assign bus.rfifo_wdata = rx_sr_q;
  assign bus.sclk        = sclk_q;
  assign bus.mosi        = mosi_q;
  assign bus.ss_n        = ss_n_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.rx_overrun  = ovr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      len_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      first_q <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= (push_slot & bus.rfifo_full) | (ovr_q & !bus.ovr_clr);
      case (state_q)
        IDLE: begin
          sclk_q <= bus.cpol;
          if (go) state_q <= LOAD;
        end
        LOAD: begin
          cpol_q  <= bus.cpol;
          cpha_q  <= bus.cpha;
          len_q   <= bus.datalen;
          div_q   <= bus.clk_div;
          cnt_q   <= bus.clk_div;
          tx_sr_q <= bus.tfifo_rdata;
          rx_sr_q <= '0;
          edge_q  <= '0;
          ss_n_q  <= 1'b0;
          sclk_q  <= bus.cpol;
          if (!bus.cpha) mosi_q <= bus.tfifo_rdata[0];
          state_q <= LEAD;
        end
        LEAD: begin
          cnt_q <= tick ? div_q : cnt_q - 1'b1;
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (!tick) cnt_q <= cnt_q - 1'b1;
          else begin
            cnt_q  <= div_q;
            sclk_q <= last ? cpol_q : !sclk_q;
            edge_q <= edge_q + 1'b1;
            if (smp) rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], bus.miso};
            else if (!last) begin
              mosi_q  <= cpha_q ? tx_sr_q[0] : tx_sr_q[1];
              tx_sr_q <= tx_sr_q >> 1;
            end
            if (last) begin
              state_q <= TRAIL;
              first_q <= 1'b1;
            end
          end
        end
        TRAIL: begin
          // The first TRAIL cycle is the push slot; the half-period hold follows it.
          if (first_q) first_q <= 1'b0;
          else if (!tick) cnt_q <= cnt_q - 1'b1;
          else if (go) state_q <= LOAD;
          else begin
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed checks of the SPI shift engine against FIFO and slave models.
module tb_spi_shift_engine;
  logic clk, rst;
  int passed, total;
  logic [31:0] tx_mem [16];
  logic [31:0] rx_mem [16];
  int tx_wr, tx_rd, rx_wr, ren_cnt, wen_cnt, viol_ren, viol_wen;
  logic miso_r, loop_v;
  spi_shift_engine_if #(.DATA_WIDTH(32), .DIV_WIDTH(8)) bus ();
  spi_shift_engine #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus.tfifo_empty = tx_rd == tx_wr;
  assign bus.miso = loop_v ? bus.mosi : miso_r;
  always @(posedge clk) begin
    if (bus.tfifo_ren) begin
      if (tx_rd == tx_wr) viol_ren <= viol_ren + 1;
      bus.tfifo_rdata <= tx_mem[tx_rd % 16];
      tx_rd <= tx_rd + 1;
      ren_cnt <= ren_cnt + 1;
    end
    if (bus.rfifo_wen) begin
      if (bus.rfifo_full) viol_wen <= viol_wen + 1;
      rx_mem[rx_wr % 16] <= bus.rfifo_wdata;
      rx_wr <= rx_wr + 1;
      wen_cnt <= wen_cnt + 1;
    end
  end
  task automatic set_cfg(input logic pol, input logic pha, input logic [4:0] dl, input logic [7:0] div);
    @(negedge clk);
    bus.cpol = pol;
    bus.cpha = pha;
    bus.datalen = dl;
    bus.clk_div = div;
    repeat (2) @(negedge clk);
  endtask
  // Pushes one word and plays an SPI slave that presents bit k of pat until the k-th sample edge.
  task automatic xfer(input logic [31:0] tx, input logic [31:0] pat, input int budget,
                      output logic [31:0] mbits, output int nsmp, output int bsy, output int badsp, output bit to);
    int idx, last_t;
    logic prev, started;
    tx_mem[tx_wr % 16] = tx;
    tx_wr = tx_wr + 1;
    idx = 0; mbits = '0; nsmp = 0; bsy = 0; badsp = 0; last_t = -1; started = 0; to = 1;
    miso_r = pat[0];
    prev = bus.sclk;
    bus.enable = 1'b1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (bus.busy) begin started = 1; bsy++; end
      if (bus.sclk !== prev) begin
        if (bus.sclk ^ bus.cpol ^ bus.cpha) begin
          if (nsmp < 32) mbits[nsmp] = bus.mosi;
          if (last_t >= 0 && t - last_t != 2 * (int'(bus.clk_div) + 1)) badsp++;
          last_t = t;
          nsmp++;
          idx++;
          if (idx < 32) miso_r = pat[idx];
        end
        prev = bus.sclk;
      end
      if (started && !bus.busy) begin to = 0; break; end
    end
    bus.enable = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.sclk, bus.mosi, bus.ss_n, bus.tfifo_ren, bus.rfifo_wen, bus.busy, bus.rx_overrun} !== 7'b0010000)
      $display("FAIL reset_outputs: got %b expected 0010000", {bus.sclk, bus.mosi, bus.ss_n, bus.tfifo_ren, bus.rfifo_wen, bus.busy, bus.rx_overrun});
    else passed++;
    total++;
    if (bus.rfifo_wdata !== 32'h0) $display("FAIL reset_wdata: got %h expected 00000000", bus.rfifo_wdata);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    bus.cpol = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sclk !== 1'b1) $display("FAIL idle_sclk_tracks_cpol: got %b expected 1", bus.sclk);
    else passed++;
    bus.cpol = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_basic();
    logic [31:0] mb; int ns, bs, bad, w0; bit to;
    set_cfg(1'b0, 1'b0, 5'd7, 8'd1);
    w0 = wen_cnt;
    xfer(32'hA5, 32'hA5, 300, mb, ns, bs, bad, to);
    total++; if (to) $display("FAIL basic_timeout: got timeout expected completion"); else passed++;
    total++; if (ns != 8) $display("FAIL basic_pulses: got %0d expected 8", ns); else passed++;
    total++; if (mb !== 32'hA5) $display("FAIL basic_mosi: got %h expected 000000a5", mb); else passed++;
    total++; if (bad != 0) $display("FAIL basic_period: got %0d bad periods expected 0", bad); else passed++;
    total++; if (bs != 38) $display("FAIL basic_word_time: got %0d expected 38", bs); else passed++;
    total++; if (wen_cnt - w0 != 1) $display("FAIL basic_wen: got %0d expected 1", wen_cnt - w0); else passed++;
    total++; if (rx_mem[(rx_wr - 1) % 16] !== 32'hA5) $display("FAIL basic_rx: got %h expected 000000a5", rx_mem[(rx_wr - 1) % 16]); else passed++;
  endtask
  task automatic test_modes();
    logic [31:0] mb; int ns, bs, bad; bit to;
    for (int m = 0; m < 4; m++) begin
      set_cfg(m[1], m[0], 5'd15, 8'd1);
      xfer(32'h1234, 32'h1234, 400, mb, ns, bs, bad, to);
      total++; if (to) $display("FAIL mode%0d_timeout: got timeout expected completion", m); else passed++;
      total++; if (rx_mem[(rx_wr - 1) % 16] !== 32'h2C48) $display("FAIL mode%0d_rx: got %h expected 00002c48", m, rx_mem[(rx_wr - 1) % 16]); else passed++;
      total++; if (mb !== 32'h1234) $display("FAIL mode%0d_mosi: got %h expected 00001234", m, mb); else passed++;
      total++; if (bus.sclk !== m[1]) $display("FAIL mode%0d_sclk_idle: got %b expected %b", m, bus.sclk, m[1]); else passed++;
    end
  endtask
  task automatic test_back_to_back();
    int r0, w0, last_ren, badsp, brk; logic started, sel, done;
    logic [31:0] exp [3];
    exp[0] = 32'hF0; exp[1] = 32'h3C; exp[2] = 32'h81;
    set_cfg(1'b0, 1'b0, 5'd7, 8'd0);
    loop_v = 1'b1;
    tx_mem[tx_wr % 16] = 32'h0F; tx_mem[(tx_wr + 1) % 16] = 32'h3C; tx_mem[(tx_wr + 2) % 16] = 32'h81;
    r0 = ren_cnt; w0 = rx_wr;
    last_ren = -1; badsp = 0; brk = 0; started = 0; sel = 0; done = 0;
    tx_wr = tx_wr + 3;
    bus.enable = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.tfifo_ren) begin
        if (last_ren >= 0 && t - last_ren != 20) badsp++;
        last_ren = t;
      end
      if (bus.busy) started = 1;
      if (!bus.ss_n) sel = 1;
      if (sel && bus.busy && bus.ss_n) brk++;
      if (started && !bus.busy) begin done = 1; break; end
    end
    bus.enable = 1'b0;
    loop_v = 1'b0;
    @(negedge clk);
    total++; if (!done) $display("FAIL b2b_timeout: got timeout expected completion"); else passed++;
    total++; if (ren_cnt - r0 != 3) $display("FAIL b2b_ren: got %0d expected 3", ren_cnt - r0); else passed++;
    total++; if (rx_wr - w0 != 3) $display("FAIL b2b_wen: got %0d expected 3", rx_wr - w0); else passed++;
    total++; if (badsp != 0) $display("FAIL b2b_word_time: got %0d bad gaps expected 0", badsp); else passed++;
    total++; if (brk != 0) $display("FAIL b2b_ss_n_gap: got %0d expected 0", brk); else passed++;
    total++; if ({bus.ss_n, bus.busy} !== 2'b10) $display("FAIL b2b_end: got ss_n,busy=%b expected 10", {bus.ss_n, bus.busy}); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rx_mem[(w0 + k) % 16] !== exp[k]) $display("FAIL b2b_rx%0d: got %h expected %h", k, rx_mem[(w0 + k) % 16], exp[k]);
      else passed++;
    end
  endtask
  task automatic test_overrun();
    logic [31:0] mb; int ns, bs, bad, w0; bit to;
    set_cfg(1'b0, 1'b0, 5'd7, 8'd0);
    bus.rfifo_full = 1'b1;
    w0 = wen_cnt;
    xfer(32'h5A, 32'h00, 300, mb, ns, bs, bad, to);
    repeat (3) @(negedge clk);
    total++; if (wen_cnt != w0) $display("FAIL ovr_no_wen: got %0d pushes expected 0", wen_cnt - w0); else passed++;
    total++; if (bus.rx_overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", bus.rx_overrun); else passed++;
    bus.rfifo_full = 1'b0;
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    total++; if (bus.rx_overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", bus.rx_overrun); else passed++;
  endtask
  task automatic test_reset_mid_word();
    int edges, w0; logic prev;
    set_cfg(1'b0, 1'b0, 5'd31, 8'd1);
    tx_mem[tx_wr % 16] = 32'hDEADBEEF;
    tx_wr = tx_wr + 1;
    w0 = wen_cnt; edges = 0; prev = bus.sclk;
    bus.enable = 1'b1;
    for (int t = 0; t < 200 && edges < 5; t++) begin
      @(negedge clk);
      if (bus.sclk !== prev) edges++;
      prev = bus.sclk;
    end
    total++; if (edges != 5) $display("FAIL rstmid_edges: got %0d expected 5", edges); else passed++;
    bus.enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.ss_n, bus.sclk} !== 3'b010) $display("FAIL rstmid_state: got busy,ss_n,sclk=%b expected 010", {bus.busy, bus.ss_n, bus.sclk});
    else passed++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (wen_cnt != w0) $display("FAIL rstmid_no_push: got %0d pushes expected 0", wen_cnt - w0); else passed++;
  endtask
  task automatic test_long_fast();
    logic [31:0] mb; int ns, bs, bad; bit to;
    set_cfg(1'b0, 1'b0, 5'd31, 8'd0);
    xfer(32'h12345678, 32'hFFFFFFFF, 300, mb, ns, bs, bad, to);
    total++; if (to) $display("FAIL long_timeout: got timeout expected completion"); else passed++;
    total++; if (rx_mem[(rx_wr - 1) % 16] !== 32'hFFFFFFFF) $display("FAIL long_rx: got %h expected ffffffff", rx_mem[(rx_wr - 1) % 16]); else passed++;
    total++; if (mb !== 32'h12345678) $display("FAIL long_mosi: got %h expected 12345678", mb); else passed++;
    total++; if (bad != 0 || ns != 32) $display("FAIL long_sclk_div2: got %0d samples, %0d bad periods expected 32, 0", ns, bad); else passed++;
    total++; if (bs != 68) $display("FAIL long_word_time: got %0d expected 68", bs); else passed++;
  endtask
  task automatic test_protocol();
    total++; if (viol_ren != 0) $display("FAIL ren_while_empty: got %0d expected 0", viol_ren); else passed++;
    total++; if (viol_wen != 0) $display("FAIL wen_while_full: got %0d expected 0", viol_wen); else passed++;
  endtask
  initial begin
    rst = 1'b1; loop_v = 1'b0; miso_r = 1'b0;
    bus.enable = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.datalen = 5'd7; bus.clk_div = 8'd1;
    bus.rfifo_full = 1'b0; bus.ovr_clr = 1'b0; bus.tfifo_rdata = '0;
    test_reset();
    test_basic();
    test_modes();
    test_back_to_back();
    test_overrun();
    test_reset_mid_word();
    test_long_fast();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
